fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode/control logic.
- Holds the architectural fetch PC and issues in-order word requests to instruction memory over a valid/ready port.
- Buffers returned instructions with their PCs in a small FIFO, and presents them to decode with pre-sliced opcode/funct3/funct7 fields.
- Supports single-cycle redirect from branch/jump resolution, discarding all stale in-flight and buffered fetches.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited in-order instruction fetch with a response FIFO and single-cycle redirect flush.
// Optional feature macro FETCH_ALIGN_CHECK_EN: flag misaligned redirect targets and stall fetch until realigned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic        fetch_misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t        state_reg;
    logic [31:0]   fetch_pc_reg;
    logic [31:0]   rsp_pc_reg;
    logic [CW-1:0] inflight_reg;
    logic [CW-1:0] discard_reg;
    logic [CW-1:0] count_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic          misalign_reg;
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [31:0]   target_pc;
    logic          target_misaligned;
    logic          pop;
    logic          push;
    logic          accept;
    logic [CW:0]   credit_used;
    logic [CW-1:0] inflight_dec;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_pc         = redirect_pc;
    assign target_misaligned = |redirect_pc[1:0];
`else
    logic unused_low_bits;
    assign unused_low_bits   = &{1'b0, redirect_pc[1:0]};
    assign target_pc         = {redirect_pc[31:2], 2'b00};
    assign target_misaligned = 1'b0;
`endif

    assign id_valid     = (count_reg != '0);
    assign pop          = id_valid && id_ready;
    // Slots already promised (buffered + outstanding) minus the one leaving this cycle.
    assign credit_used  = {1'b0, count_reg} + {1'b0, inflight_reg} - (CW + 1)'(pop);
    assign inflight_dec = inflight_reg - CW'(imem_rsp_valid);

    assign imem_req_valid = (state_reg != BOOT) && !redirect_valid && !misalign_reg
                            && (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc_reg;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && !redirect_valid && (discard_reg == '0);

    assign id_instr       = instr_mem[rd_ptr_reg];
    assign id_pc          = pc_mem[rd_ptr_reg];
    assign id_opcode      = id_instr[6:0];
    assign id_funct3      = id_instr[14:12];
    assign id_funct7      = id_instr[31:25];
    assign fetch_misalign = misalign_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
            instr_mem[wr_ptr_reg] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= BOOT;
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            inflight_reg <= '0;
            discard_reg  <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            misalign_reg <= 1'b0;
        end else if (redirect_valid) begin
            // Everything still outstanding belongs to the old path and must be dropped.
            fetch_pc_reg <= target_pc;
            rsp_pc_reg   <= target_pc;
            inflight_reg <= inflight_dec;
            discard_reg  <= inflight_dec;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            misalign_reg <= target_misaligned;
            state_reg    <= (inflight_dec != '0) ? FLUSH : RUN;
        end else begin
            if (accept) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            inflight_reg <= inflight_reg + CW'(accept) - CW'(imem_rsp_valid);
            if (imem_rsp_valid) begin
                if (discard_reg != '0) begin
                    discard_reg <= discard_reg - CW'(1);
                end else begin
                    rsp_pc_reg <= rsp_pc_reg + 32'd4;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
            case (state_reg)
                BOOT: state_reg <= RUN;
                FLUSH: begin
                    if ((discard_reg == CW'(1) && imem_rsp_valid) || discard_reg == '0) begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; an in-order latency memory model feeds the DUT and
// the expected decode stream is simply "consecutive words from the last reset/redirect target".
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .fetch_misalign(fetch_misalign)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          pops = 0;
    int          accepts = 0;
    bit          halted = 1'b0;
    logic [31:0] exp_req_addr = '0;
    logic [31:0] exp_pc_q[$];
    mreq_t       mem_q[$];
    logic [31:0] epc;
    logic [31:0] ein;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0300) return 32'h4000_5033;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    // Expected stream after a reset or redirect: consecutive words from the target.
    task automatic restart(input logic [31:0] base);
        exp_pc_q.delete();
        for (int i = 0; i < 160; i++) exp_pc_q.push_back(base + (32'(i) << 2));
        exp_req_addr = base;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic [31:0] exp_base);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        restart(exp_base);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: record accepted requests, answer them in order after lat cycles.
    always @(negedge clk) begin
        if (rst) begin
            mem_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            accepts++;
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        end
    end

    always @(posedge clk) begin
        #1;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    end

    // Monitor: request address stream and decode-side scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (redirect_valid) check("no_req_in_redirect", imem_req_valid, 0);
            else if (halted) check("no_req_while_misaligned", imem_req_valid, 0);
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_req_addr);
                exp_req_addr = exp_req_addr + 32'd4;
            end
            if (id_valid && id_ready && !redirect_valid) begin
                pops++;
                if (exp_pc_q.size() == 0) begin
                    fail_now("unexpected_pop", {id_pc, id_instr});
                end else begin
                    epc = exp_pc_q.pop_front();
                    ein = memf(epc);
                    check("id_pc_instr", {id_pc, id_instr}, {epc, ein});
                    check("id_fields", {id_opcode, id_funct3, id_funct7}, {ein[6:0], ein[14:12], ein[31:25]});
                end
            end
        end
    end

    task automatic do_reset(input int l, input bit idr);
        rst = 1'b1;
        redirect_valid = 1'b0;
        halted = 1'b0;
        lat = l;
        id_ready = idr;
        imem_req_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("reset_outputs", {imem_req_valid, id_valid, fetch_misalign}, 0);
        check("reset_addr", imem_req_addr, RESET_PC);
        restart(RESET_PC);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0;
        int p0;
        int since;
        logic [31:0] tgt;

        // Reset release, L=1: first request in cycle 1, first id_valid in cycle 3.
        do_reset(1, 1'b1);
        @(negedge clk); check("boot_no_req", imem_req_valid, 0);
        @(negedge clk); check("req_c1", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
        @(negedge clk); check("req_c2", {imem_req_valid, imem_req_addr}, {1'b1, 32'h4});
        check("id_valid_c2", id_valid, 0);
        @(negedge clk); check("req_c3", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8});
        check("first_id_c3", {id_valid, id_pc}, {1'b1, 32'h0});

        // Credit limit with decode stalled.
        do_reset(1, 1'b0);
        a0 = accepts;
        repeat (12) tick();
        check("credit_accepts", accepts - a0, DEPTH);
        id_ready = 1'b1;
        @(negedge clk); check("resume_on_pop", imem_req_valid, 1);

        // Redirect with two requests in flight at L=3.
        do_reset(3, 1'b1);
        for (int k = 0; k < 20 && (accepts - a0) < 2; k++) begin
            a0 = (k == 0) ? accepts : a0;
            tick();
        end
        a0 = accepts;
        redirect_to(32'h100, 32'h100);
        p0 = pops;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk); check("redir_next_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
        for (int k = 0; k < 30 && pops == p0; k++) tick();
        check("redir_pop_seen", pops > p0, 1);

        // Response and redirect in the same cycle, steady state L=1 (inflight=1).
        do_reset(1, 1'b1);
        repeat (10) tick();
        check("steady_rsp_present", imem_rsp_valid, 1);
        redirect_to(32'h100, 32'h100);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("same_cycle_fifo_empty", id_valid, 0);
        check("same_cycle_next_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});

        // Sustained throughput at L=DEPTH-2.
        do_reset(2, 1'b1);
        repeat (10) tick();
        p0 = pops;
        repeat (20) tick();
        check("throughput_20", pops - p0, 20);

        // Field slicing.
        tick();
        redirect_to(32'h300, 32'h300);
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 20 && !(id_valid && id_pc == 32'h300); k++) @(negedge clk);
        check("fields_head", {id_valid, id_pc}, {1'b1, 32'h300});
        check("fields", {id_opcode, id_funct3, id_funct7}, {7'h33, 3'h5, 7'h20});

        // Misaligned redirect target.
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        exp_pc_q.delete();
        halted = 1'b1;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk); check("misalign_set", fetch_misalign, 1);
        repeat (8) @(negedge clk);
        check("misalign_sticky", fetch_misalign, 1);
        tick();
        halted = 1'b0;
        redirect_to(32'h200, 32'h200);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("misalign_cleared", fetch_misalign, 0);
        check("misalign_resume", {imem_req_valid, imem_req_addr}, {1'b1, 32'h200});
`else
        redirect_to(32'h102, 32'h100);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("misalign_tied_low", fetch_misalign, 0);
        check("low_bits_forced", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
`endif

        // Randomized traffic with redirects, latency changes and one mid-run reset.
        since = 0;
        for (int it = 0; it < 3000; it++) begin
            tick();
            if (it == 1500) begin
                do_reset(1 + $urandom_range(0, 2), 1'b1);
                since = 0;
                continue;
            end
            if (it % 50 == 0) lat = 1 + $urandom_range(0, 3);
            id_ready = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            since++;
            if ($urandom_range(0, 19) == 0 || since > 60) begin
                tgt = $urandom;
                if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifdef FETCH_ALIGN_CHECK_EN
                tgt = tgt & 32'hFFFF_FFFC;
`endif
                redirect_to(tgt, tgt & 32'hFFFF_FFFC);
                since = 0;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();
        check("liveness_pops", pops >= 300, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
